// File: rtl/serial_frame_pkg.sv
// Shared FSM encoding and line levels for serial_frame_ctrl.
// SERIAL_FRAME_PARITY_EN adds the PARITY state.
package serial_frame_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t STOP  = 3'd3;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam state_t PARITY = 3'd4;
`endif

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_ctrl_bit_tick_gen.sv
// Bit pacing counter: counts 0..DIV-1 while enabled and pulses bit_tick on the
// last count. Held at zero while clear is high.
module bit_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Word-to-serial framer: start bit, WIDTH data bits LSB-first, stop bit, DIV clk per bit.
// Define SERIAL_FRAME_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             bit_tick;
    logic             idle;
`ifdef SERIAL_FRAME_PARITY_EN
    logic             parity;
`endif

    assign idle = (state == IDLE);

    // Pacing restarts from zero on every frame because it is held clear in IDLE.
    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (idle),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
`ifdef SERIAL_FRAME_PARITY_EN
                        parity <= ^in_data;
`endif
                        state <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == LAST_BIT)
`ifdef SERIAL_FRAME_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_FRAME_PARITY_EN
                PARITY: begin
                    if (bit_tick)
                        state <= STOP;
                end
`endif
                STOP: begin
                    if (bit_tick)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so in_* never reach them combinationally.
    always_comb begin
        serial_out = IDLE_LEVEL;
        case (state)
            START:   serial_out = START_LEVEL;
            DATA:    serial_out = shreg[0];
`ifdef SERIAL_FRAME_PARITY_EN
            PARITY:  serial_out = parity;
`endif
            default: serial_out = IDLE_LEVEL;
        endcase
    end

    assign in_ready = idle;
    assign busy     = !idle;
    assign done     = (state == STOP) && bit_tick;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Self-checking bench for serial_frame_ctrl: line bits are predicted from the
// frame rules (start, data LSB-first, optional parity, stop) per cycle offset.
module tb_serial_frame_ctrl;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int W1 = 4;
    localparam int D1 = 1;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL  = (W + 2 + PB) * D;
    localparam int FL1 = (W1 + 2 + PB) * D1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, serial_out, busy, done;
    logic [W1-1:0] in_data1 = '0;
    logic          in_valid1 = 1'b0;
    logic          in_ready1, serial_out1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_frame_ctrl #(.WIDTH(W), .DIV(D)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .serial_out(serial_out), .busy(busy), .done(done)
    );

    serial_frame_ctrl #(.WIDTH(W1), .DIV(D1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .serial_out(serial_out1), .busy(busy1), .done(done1)
    );

    // Frame bit i of a w-bit word: 0 = start, 1..w = data LSB-first, then parity, then stop.
    function automatic logic exp_bit(input logic [31:0] d, input int w, input int i);
        if (i == 0) return 1'b0;
        if (i <= w) return d[i-1];
        if (PB == 1 && i == w + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        step();
        obs = {serial_out, in_ready, busy, done};
        vectors++;
        if (obs !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_state got %b want 1100", obs);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== 4'b1100) begin
                miscompares++;
                $display("FAIL idle_after_reset c=%0d got %b want 1100", c, obs);
            end
        end
    endtask

    task automatic test_frames();
        logic [W-1:0] words[8];
        logic [3:0]   obs;
        words[0] = 8'hA5; words[1] = 8'h07; words[2] = 8'h00; words[3] = 8'hFF;
        for (int i = 4; i < 8; i++) words[i] = W'($urandom);
        for (int n = 0; n < 8; n++) begin
            in_data  = words[n];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            in_data  = W'($urandom);
            for (int k = 0; k < FL; k++) begin
                obs = {serial_out, in_ready, busy, done};
                vectors++;
                if (obs !== {exp_bit(32'(words[n]), W, k / D), 1'b0, 1'b1, (k == FL - 1)}) begin
                    miscompares++;
                    $display("FAIL frame w=%h k=%0d got %b want %b", words[n], k, obs,
                             {exp_bit(32'(words[n]), W, k / D), 1'b0, 1'b1, (k == FL - 1)});
                end
                step();
            end
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== 4'b1100) begin
                miscompares++;
                $display("FAIL frame_end w=%h got %b want 1100", words[n], obs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w[2];
        logic [3:0]   obs;
        w[0] = 8'h00; w[1] = 8'hFF;
        in_data  = w[0];
        in_valid = 1'b1;
        step();
        in_data = w[1];
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                obs = {serial_out, in_ready, busy, done};
                vectors++;
                if (obs !== {exp_bit(32'(w[f]), W, k / D), 1'b0, 1'b1, (k == FL - 1)}) begin
                    miscompares++;
                    $display("FAIL b2b f=%0d k=%0d got %b want %b", f, k, obs,
                             {exp_bit(32'(w[f]), W, k / D), 1'b0, 1'b1, (k == FL - 1)});
                end
                step();
            end
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== 4'b1100) begin
                miscompares++;
                $display("FAIL b2b_gap f=%0d got %b want 1100", f, obs);
            end
            if (f == 1) in_valid = 1'b0;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_ignored_input();
        logic [W-1:0] w;
        logic [3:0]   obs;
        w = W'($urandom);
        in_data  = w;
        in_valid = 1'b1;
        step();
        for (int k = 0; k < FL; k++) begin
            in_data  = W'($urandom);
            in_valid = (k == FL - 1) ? 1'b0 : 1'($urandom);
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== {exp_bit(32'(w), W, k / D), 1'b0, 1'b1, (k == FL - 1)}) begin
                miscompares++;
                $display("FAIL ignored w=%h k=%0d got %b want %b", w, k, obs,
                         {exp_bit(32'(w), W, k / D), 1'b0, 1'b1, (k == FL - 1)});
            end
            step();
        end
        for (int c = 0; c < 2; c++) begin
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== 4'b1100) begin
                miscompares++;
                $display("FAIL ignored_idle c=%0d got %b want 1100", c, obs);
            end
            step();
        end
    endtask

    task automatic test_div1();
        logic [3:0] obs;
        in_data1  = 4'h3;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        for (int k = 0; k < FL1; k++) begin
            obs = {serial_out1, in_ready1, busy1, done1};
            vectors++;
            if (obs !== {exp_bit(32'h3, W1, k), 1'b0, 1'b1, (k == FL1 - 1)}) begin
                miscompares++;
                $display("FAIL div1 k=%0d got %b want %b", k, obs,
                         {exp_bit(32'h3, W1, k), 1'b0, 1'b1, (k == FL1 - 1)});
            end
            step();
        end
        obs = {serial_out1, in_ready1, busy1, done1};
        vectors++;
        if (obs !== 4'b1100) begin
            miscompares++;
            $display("FAIL div1_end got %b want 1100", obs);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] w;
        logic [3:0]   obs;
        w = W'($urandom);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3 * D; k++) begin
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== {exp_bit(32'(w), W, k / D), 1'b0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL abort_pre k=%0d got %b want %b", k, obs,
                         {exp_bit(32'(w), W, k / D), 3'b010});
            end
            step();
        end
        #2 rst = 1'b1;
        #1;
        obs = {serial_out, in_ready, busy, done};
        vectors++;
        if (obs !== 4'b1100) begin
            miscompares++;
            $display("FAIL abort_immediate got %b want 1100", obs);
        end
        // in_valid during reset must not start a frame
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== 4'b1100) begin
                miscompares++;
                $display("FAIL valid_in_reset c=%0d got %b want 1100", c, obs);
            end
        end
        #1 rst = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            obs = {serial_out, in_ready, busy, done};
            vectors++;
            if (obs !== {exp_bit(32'h5A, W, k / D), 1'b0, 1'b1, (k == FL - 1)}) begin
                miscompares++;
                $display("FAIL post_reset k=%0d got %b want %b", k, obs,
                         {exp_bit(32'h5A, W, k / D), 1'b0, 1'b1, (k == FL - 1)});
            end
            step();
        end
        obs = {serial_out, in_ready, busy, done};
        vectors++;
        if (obs !== 4'b1100) begin
            miscompares++;
            $display("FAIL post_reset_end got %b want 1100", obs);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignored_input();
        test_div1();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
